// File: rtl/sd_pkg.sv
// Shared constants, error codes, state encoding and CRC-16 helper for the
// SD single-block read sequencer.
package sd_pkg;

  localparam logic [7:0]  CMD17       = 8'h51;
  localparam logic [7:0]  START_TOKEN = 8'hFE;
  localparam logic [7:0]  IDLE_BYTE   = 8'hFF;
  localparam logic [47:0] IDLE_FRAME  = 48'hFFFF_FFFF_FFFF;

  localparam logic [1:0] ERR_R1_TIMEOUT = 2'd0;
  localparam logic [1:0] ERR_R1_NONZERO = 2'd1;
  localparam logic [1:0] ERR_TOKEN      = 2'd2;
  localparam logic [1:0] ERR_CRC        = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_R1,
    S_TOKEN,
    S_DATA,
    S_CRC,
    S_TAIL
  } state_t;

  // CRC-16-CCITT (0x1021), MSB first, one byte per call
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] din);
    logic [15:0] c;
    c = crc ^ {din, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/sd_crc16.sv
// Byte-wide CRC-16-CCITT accumulator with synchronous clear and enable.
module sd_crc16
  import sd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [15:0] crc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= 16'h0000;
    end else if (clr) begin
      crc <= 16'h0000;
    end else if (en) begin
      crc <= crc16_byte(crc, din);
    end
  end

endmodule

// File: rtl/sd_read_ctrl.sv
// CMD17 single-block read sequencer driving an SPI master handshake.
// Optional CRC-16 check of the data block is built when SD_READ_CRC16_EN is defined.
module sd_read_ctrl
  import sd_pkg::*;
#(
  parameter int BYTE_ADDR     = 0,
  parameter int NCR_MAX       = 8,
  parameter int TOKEN_TIMEOUT = 4096
) (
  input  logic        rd_clk_i,
  input  logic        rd_rst_i,
  input  logic        rd_req_i,
  input  logic [31:0] rd_addr_i,
  output logic        rd_busy_o,
  output logic        rd_done_o,
  output logic        rd_err_o,
  output logic [1:0]  rd_err_code_o,
  output logic [7:0]  rd_byte_o,
  output logic        rd_valid_o,
  output logic [8:0]  rd_idx_o,
  output logic        spi_start_o,
  output logic        spi_len_o,
  output logic [47:0] instruction_sd_o,
  output logic        spi_cs_n_o,
  input  logic        spi_done_i,
  input  logic [47:0] spi_data_i
);

  localparam logic [7:0]  NCR_LIM = 8'(NCR_MAX);
  localparam logic [12:0] TOK_LIM = 13'(TOKEN_TIMEOUT);

  state_t      state;
  logic        pending;
  logic [31:0] addr_reg;
  logic [7:0]  ncr_cnt;
  logic [12:0] tok_cnt;
  logic [8:0]  data_cnt;
  logic        crc_slot;
  logic        err_flag;
  logic [7:0]  rx_byte;
  logic [31:0] cmd_arg;
  logic        crc_bad;
  logic        unused_bits;

  assign rx_byte     = spi_data_i[7:0];
  assign unused_bits = ^spi_data_i[47:8];
  assign cmd_arg     = (BYTE_ADDR != 0) ? (addr_reg << 9) : addr_reg;

`ifdef SD_READ_CRC16_EN
  logic [7:0]  crc_hi;
  logic [15:0] crc_val;

  sd_crc16 u_crc (
    .clk (rd_clk_i),
    .rst (rd_rst_i),
    .clr (state == S_IDLE && rd_req_i),
    .en  (state == S_DATA && pending && spi_done_i),
    .din (rx_byte),
    .crc (crc_val)
  );

  assign crc_bad = ({crc_hi, rx_byte} != crc_val);
`else
  assign crc_bad = 1'b0;
`endif

  always_ff @(posedge rd_clk_i or posedge rd_rst_i) begin
    if (rd_rst_i) begin
      state            <= S_IDLE;
      pending          <= 1'b0;
      addr_reg         <= 32'd0;
      ncr_cnt          <= 8'd0;
      tok_cnt          <= 13'd0;
      data_cnt         <= 9'd0;
      crc_slot         <= 1'b0;
      err_flag         <= 1'b0;
      rd_busy_o        <= 1'b0;
      rd_done_o        <= 1'b0;
      rd_err_o         <= 1'b0;
      rd_err_code_o    <= ERR_R1_TIMEOUT;
      rd_byte_o        <= 8'd0;
      rd_valid_o       <= 1'b0;
      rd_idx_o         <= 9'd0;
      spi_start_o      <= 1'b0;
      spi_len_o        <= 1'b0;
      instruction_sd_o <= IDLE_FRAME;
      spi_cs_n_o       <= 1'b1;
`ifdef SD_READ_CRC16_EN
      crc_hi           <= 8'd0;
`endif
    end else begin
      spi_start_o <= 1'b0;
      rd_valid_o  <= 1'b0;
      rd_done_o   <= 1'b0;
      rd_err_o    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rd_req_i) begin
            addr_reg      <= rd_addr_i;
            rd_busy_o     <= 1'b1;
            spi_cs_n_o    <= 1'b0;
            err_flag      <= 1'b0;
            rd_err_code_o <= ERR_R1_TIMEOUT;
            ncr_cnt       <= 8'd0;
            tok_cnt       <= 13'd0;
            data_cnt      <= 9'd0;
            crc_slot      <= 1'b0;
            pending       <= 1'b0;
            state         <= S_CMD;
          end
        end
        default: begin
          if (!pending) begin
            // first frame of a state; later frames are reissued straight from the done cycle
            spi_start_o <= 1'b1;
            pending     <= 1'b1;
            if (state == S_CMD) begin
              spi_len_o        <= 1'b1;
              instruction_sd_o <= {CMD17, cmd_arg, IDLE_BYTE};
            end else begin
              spi_len_o        <= 1'b0;
              instruction_sd_o <= IDLE_FRAME;
            end
          end else if (spi_done_i) begin
            case (state)
              S_CMD: begin
                state   <= S_R1;
                pending <= 1'b0;
              end
              S_R1: begin
                if (rx_byte == IDLE_BYTE) begin
                  if (8'(ncr_cnt + 8'd1) >= NCR_LIM) begin
                    state <= S_TAIL; pending <= 1'b0; spi_cs_n_o <= 1'b1;
                    err_flag <= 1'b1; rd_err_code_o <= ERR_R1_TIMEOUT;
                  end else begin
                    ncr_cnt     <= ncr_cnt + 8'd1;
                    spi_start_o <= 1'b1;
                  end
                end else if (rx_byte == 8'h00) begin
                  state   <= S_TOKEN;
                  pending <= 1'b0;
                end else begin
                  state <= S_TAIL; pending <= 1'b0; spi_cs_n_o <= 1'b1;
                  err_flag <= 1'b1; rd_err_code_o <= ERR_R1_NONZERO;
                end
              end
              S_TOKEN: begin
                if (rx_byte == START_TOKEN) begin
                  state   <= S_DATA;
                  pending <= 1'b0;
                end else if (rx_byte[7:4] == 4'h0 || 13'(tok_cnt + 13'd1) >= TOK_LIM) begin
                  state <= S_TAIL; pending <= 1'b0; spi_cs_n_o <= 1'b1;
                  err_flag <= 1'b1; rd_err_code_o <= ERR_TOKEN;
                end else begin
                  tok_cnt     <= tok_cnt + 13'd1;
                  spi_start_o <= 1'b1;
                end
              end
              S_DATA: begin
                rd_byte_o  <= rx_byte;
                rd_valid_o <= 1'b1;
                rd_idx_o   <= data_cnt;
                if (data_cnt == 9'd511) begin
                  state   <= S_CRC;
                  pending <= 1'b0;
                end else begin
                  data_cnt    <= data_cnt + 9'd1;
                  spi_start_o <= 1'b1;
                end
              end
              S_CRC: begin
                if (!crc_slot) begin
                  crc_slot    <= 1'b1;
                  spi_start_o <= 1'b1;
`ifdef SD_READ_CRC16_EN
                  crc_hi      <= rx_byte;
`endif
                end else begin
                  state      <= S_TAIL;
                  pending    <= 1'b0;
                  spi_cs_n_o <= 1'b1;
                  if (crc_bad) begin
                    err_flag      <= 1'b1;
                    rd_err_code_o <= ERR_CRC;
                  end
                end
              end
              S_TAIL: begin
                rd_done_o <= 1'b1;
                rd_err_o  <= err_flag;
                rd_busy_o <= 1'b0;
                pending   <= 1'b0;
                state     <= S_IDLE;
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: doc/sd_read_ctrl.md
# sd_read_ctrl

Single-block read sequencer for the SD card in SPI mode. It runs after card initialisation has completed and owns the SPI master for one transaction. For each request it issues CMD17, polls the R1 response, waits for the data start token, then streams the 512 data bytes to the consumer. It drives the same SPI master handshake as the init controller: 48-bit frame, start pulse, done pulse and received data.

## Interface
Parameters:
- `BYTE_ADDR`, default 0. When 0, the address is a block address (SDHC). When 1, the argument is `rd_addr_i << 9` (SDSC).
- `NCR_MAX`, default 8. Maximum number of byte slots polled for R1.
- `TOKEN_TIMEOUT`, default 4096. Maximum number of byte slots polled for the start token.

Ports (name, direction, width, meaning):
- `rd_clk_i` in 1: the single clock for the block.
- `rd_rst_i` in 1: reset, asynchronous and active-high.
- `rd_req_i` in 1: read request, sampled only in IDLE.
- `rd_addr_i` in 32: block address, captured when the request is accepted.
- `rd_busy_o` out 1: high from request acceptance until the DONE/ERR cycle.
- `rd_done_o` out 1: one-cycle pulse at the end of a transaction, with or without error.
- `rd_err_o` out 1: valid with `rd_done_o`.
- `rd_err_code_o` out 2: 0 = R1 timeout, 1 = R1 nonzero, 2 = token timeout / error token, 3 = CRC mismatch.
- `rd_byte_o` out 8: data byte.
- `rd_valid_o` out 1: one-cycle strobe per data byte.
- `rd_idx_o` out 9: byte index 0..511.
- `spi_start_o` out 1: one-cycle start pulse to the SPI master.
- `spi_len_o` out 1: 1 = 48-bit frame, 0 = 8-bit frame.
- `instruction_sd_o` out 48: transmit frame.
- `spi_cs_n_o` out 1: card select, active low.
- `spi_done_i` in 1: one-cycle done pulse from the SPI master.
- `spi_data_i` in 48: received bits; for a byte frame the byte is in [7:0].

## Operation
States: IDLE → CMD → R1 → TOKEN → DATA → CRC → TAIL → IDLE.

- **IDLE**:
  - `rd_req_i` = 1 latches the address, asserts `rd_busy_o` and `spi_cs_n_o` = 0, and moves to CMD.
- **CMD**:
  - Sends the frame {8'h51, arg[31:0], 8'hFF} with `spi_len_o` = 1.
  - On `spi_done_i`, moves to R1.
- **R1**:
  - Sends byte frames of 8'hFF.
  - A received byte of 8'hFF increments the NCR counter.
  - Reaching `NCR_MAX` slots: error 0.
  - Received byte 8'h00 → TOKEN.
  - Any other byte → error 1.
- **TOKEN**:
  - Sends byte frames of 8'hFF.
  - 8'hFF: increment the 13-bit timeout counter.
  - 8'hFE → DATA.
  - Byte matching 8'b0000xxxx (error token), or the counter reaching `TOKEN_TIMEOUT`: error 2.
- **DATA**:
  - Each `spi_done_i` drives `rd_byte_o` = `spi_data_i[7:0]`, pulses `rd_valid_o` and presents `rd_idx_o` = current count.
  - After index 511 → CRC.
  - There is no backpressure; the consumer must accept one byte per strobe.
- **CRC**:
  - Two byte slots are received.
  - Under the CRC option they are compared against the computed value, otherwise they are discarded.
- **TAIL**:
  - Drives `spi_cs_n_o` = 1, sends one 8'hFF byte (8 trailing clocks), then pulses `rd_done_o`.
- **Any error**:
  - Skips directly to TAIL, then `rd_done_o` is pulsed with `rd_err_o` = 1 and the code held.
- `spi_done_i` outside a pending frame is ignored.
- `rd_req_i` while busy is ignored and not queued.

## Timing
- Reset values:
  - All strobes are 0, `rd_busy_o` = 0, `rd_err_o` = 0, `rd_err_code_o` = 0.
  - `spi_cs_n_o` = 1, `spi_start_o` = 0, `spi_len_o` = 0.
  - `instruction_sd_o` = 48'hFFFF_FFFF_FFFF, `rd_byte_o` = 0, `rd_idx_o` = 0.
- `spi_start_o` pulses on the cycle after entering a frame-issuing state, and one cycle after each `spi_done_i` while further frames are needed.
- `rd_busy_o` rises the cycle after `rd_req_i` is sampled.
- `rd_valid_o` and `rd_byte_o` are registered, one cycle after `spi_done_i`.
- `rd_done_o` occurs one cycle after the TAIL frame's `spi_done_i`. `rd_busy_o` falls in the same cycle.
- A new request is accepted the cycle after `rd_done_o`.
- Reset mid-transaction: immediate return to IDLE, `spi_cs_n_o` = 1, no `rd_done_o`.
- Counters saturate and never wrap. The address shift for `BYTE_ADDR` = 1 truncates to 32 bits.

## Configuration
- `SD_READ_CRC16_EN` defined:
  - CRC-16-CCITT (polynomial 0x1021, init 0) is accumulated over the 512 data bytes.
  - The received CRC (MSB byte first) is compared against it; a mismatch gives error 3.
- `SD_READ_CRC16_EN` not defined:
  - No CRC logic is built; the CRC bytes are clocked and discarded.
  - Error code 3 is never produced.

## Structure
- Package `sd_pkg` holds:
  - CMD17 opcode 8'h51, start token 8'hFE, idle byte 8'hFF.
  - Idle frame 48'hFFFF_FFFF_FFFF.
  - Error code constants.
  - State encoding.
- Sub-module `sd_crc16`: byte-wide CRC-16 update with clear and enable. It is instantiated only under `SD_READ_CRC16_EN`.

## Test plan
- Addr 0x0000_0010, `BYTE_ADDR` = 0, R1 = 00 on the 2nd slot, token after 3 FF, 512 bytes = idx[7:0] → CMD frame 48'h5100000010FF, 512 strobes with matching idx/byte, `rd_done_o` with `rd_err_o` = 0.
- R1 always FF → exactly 8 polls, then `rd_err_code_o` = 0, and cs high before done.
- R1 = 0x04 → error 1. Token 0x08 → error 2. FF for 4096 slots → error 2.
- `SD_READ_CRC16_EN` with a corrupted CRC byte → error 3. Without the macro → `rd_err_o` = 0.
- Assert reset at data byte 200 → cs = 1, no done pulse; a subsequent request completes normally.
- `rd_req_i` held during busy → exactly one transaction; `BYTE_ADDR` = 1 with addr 3 → argument 0x0000_0600.
